// File: rtl/reorder_buffer_if.sv
// Bundle of ROB signals: rename allocation, execution completion, in-order
// retire and occupancy status. The master side is the surrounding pipeline.
interface reorder_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_rd;
  logic [AREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_pd;
  logic [PREG_W-1:0] alloc_old_pd;
  logic [IDX_W-1:0]  alloc_idx;

  logic              cmp_valid;
  logic [IDX_W-1:0]  cmp_idx;
  logic [DATA_W-1:0] cmp_result;

  logic              ret_valid;
  logic              ret_ready;
  logic              ret_has_rd;
  logic [AREG_W-1:0] ret_rd;
  logic [PREG_W-1:0] ret_pd;
  logic [PREG_W-1:0] ret_old_pd;
  logic [DATA_W-1:0] ret_result;

  logic [IDX_W:0]    count;
  logic              empty;

  modport master (
    output alloc_valid, alloc_has_rd, alloc_rd, alloc_pd, alloc_old_pd,
    output cmp_valid, cmp_idx, cmp_result, ret_ready,
    input  alloc_ready, alloc_idx, ret_valid, ret_has_rd, ret_rd, ret_pd,
    input  ret_old_pd, ret_result, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_rd, alloc_pd, alloc_old_pd,
    input  cmp_valid, cmp_idx, cmp_result, ret_ready,
    output alloc_ready, alloc_idx, ret_valid, ret_has_rd, ret_rd, ret_pd,
    output ret_old_pd, ret_result, count, empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates tags in program order at the tail, takes
// out-of-order completions, and retires complete entries from the head.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  reorder_buffer_if.slave  rob
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0]  head_q, tail_q;
  logic [IDX_W:0]    count_q;
  logic [DEPTH-1:0]  valid_q, complete_q;
  logic              has_rd_q [DEPTH];
  logic [AREG_W-1:0] rd_q     [DEPTH];
  logic [PREG_W-1:0] pd_q     [DEPTH];
  logic [PREG_W-1:0] old_pd_q [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];

  logic alloc_fire, cmp_hit, ret_fire;

  // Space freed by a same-cycle retire is not visible until the next cycle.
  assign rob.alloc_ready = (count_q != FULL_COUNT);
  assign rob.alloc_idx   = tail_q;
  assign alloc_fire      = rob.alloc_valid && rob.alloc_ready;
  assign cmp_hit         = rob.cmp_valid && valid_q[rob.cmp_idx];

  assign rob.ret_valid  = valid_q[head_q] && complete_q[head_q];
  assign rob.ret_has_rd = has_rd_q[head_q];
  assign rob.ret_rd     = rd_q[head_q];
  assign rob.ret_pd     = pd_q[head_q];
  assign rob.ret_old_pd = old_pd_q[head_q];
  assign rob.ret_result = result_q[head_q];
  assign ret_fire       = rob.ret_valid && rob.ret_ready;

  assign rob.count = count_q;
  assign rob.empty = (count_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      complete_q <= '0;
      // NOTE: the payload array is reset too, so ret_* read back zero from the
      // empty head after reset instead of stale or unknown data.
      for (int i = 0; i < DEPTH; i++) begin
        has_rd_q[i] <= 1'b0;
        rd_q[i]     <= '0;
        pd_q[i]     <= '0;
        old_pd_q[i] <= '0;
        result_q[i] <= '0;
      end
    end else begin
      if (cmp_hit) begin
        complete_q[rob.cmp_idx] <= 1'b1;
        result_q[rob.cmp_idx]   <= rob.cmp_result;
      end

      if (alloc_fire) begin
        valid_q[tail_q]    <= 1'b1;
        complete_q[tail_q] <= 1'b0;
        has_rd_q[tail_q]   <= rob.alloc_has_rd;
        rd_q[tail_q]       <= rob.alloc_rd;
        pd_q[tail_q]       <= rob.alloc_pd;
        old_pd_q[tail_q]   <= rob.alloc_old_pd;
        tail_q             <= tail_q + 1'b1;
      end

      // NOTE: non-blocking assignments take the last write, so a retire here
      // wins over a completion to the head entry in the same cycle.
      if (ret_fire) begin
        valid_q[head_q]    <= 1'b0;
        complete_q[head_q] <= 1'b0;
        head_q             <= head_q + 1'b1;
      end

      case ({alloc_fire, ret_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order reorder buffer (ROB) between the rename stage and the retire logic of the out-of-order RV32I core.
- Each renamed instruction is allocated an entry in program order; the returned tag travels with it into the reservation station.
- Execution units mark entries complete out of order.
- Entries retire strictly in order, handing rd, new pd, old pd and the result to the register-file writeback and free-pool release logic.

Parameters:
DEPTH, 16, number of ROB entries; must be a power of 2
IDX_W, $clog2(DEPTH), tag width (4 at default)
AREG_W, 5, architectural register index width (32 arch regs)
PREG_W, 6, physical register index width (64 physical regs)
DATA_W, 32, result width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
alloc_valid  in  1  rename presents an instruction for allocation
alloc_ready  out  1  ROB can accept an allocation (not full)
alloc_has_rd  in  1  instruction writes a destination (0 for SW)
alloc_rd  in  AREG_W  architectural destination
alloc_pd  in  PREG_W  newly mapped physical destination
alloc_old_pd  in  PREG_W  previous mapping of rd, freed at retire
alloc_idx  out  IDX_W  tag assigned to the allocating instruction (= tail)
cmp_valid  in  1  execution unit reports completion
cmp_idx  in  IDX_W  tag of the completing entry
cmp_result  in  DATA_W  result value
ret_valid  out  1  head entry is valid and complete
ret_ready  in  1  retire logic accepts the head entry this cycle
ret_has_rd  out  1  head has_rd
ret_rd  out  AREG_W  head rd
ret_pd  out  PREG_W  head pd
ret_old_pd  out  PREG_W  head old pd, to return to the free pool
ret_result  out  DATA_W  head result
count  out  IDX_W+1  number of occupied entries
empty  out  1  count == 0

Behaviour:
- Storage is a circular buffer with per-entry valid and complete bits, plus has_rd/rd/pd/old_pd/result fields.
- head and tail are IDX_W-bit pointers that wrap modulo DEPTH. count is a registered occupancy counter.
- Reset (async, immediate):
  - head = tail = count = 0; all valid and complete bits = 0.
  - Outputs: alloc_ready = 1, alloc_idx = 0, ret_valid = 0, empty = 1, count = 0; ret_* data = 0.
  - Reset asserted mid-operation discards every entry. No retire fires during or after reset until new allocations complete.
- Allocation fire = alloc_valid && alloc_ready.
  - alloc_ready = (count != DEPTH), computed from the current count only. A retire in the same cycle does not free space for a same-cycle allocation.
  - alloc_idx = tail combinationally, so it is valid in the same cycle as the fire.
  - On the clock edge: entry[tail] gets fields, valid = 1, complete = 0; tail = tail + 1 (wraps DEPTH-1 -> 0).
- Completion: on a cycle with cmp_valid && entry[cmp_idx].valid, the edge sets complete = 1 and result = cmp_result.
  - Completion to an invalid (unallocated) entry is ignored; no state changes.
  - Completion to the tail entry in the same cycle it is being allocated is ignored, because that entry is not yet valid.
  - A repeated completion to an already complete entry overwrites result.
- Retire outputs are driven combinationally from entry[head]. ret_valid = valid && complete.
- Retire fire = ret_valid && ret_ready. On the edge: entry[head].valid = 0, complete = 0, head = head + 1 (wraps).
  - While ret_ready = 0, the head entry and all ret_* outputs hold stable.
- Latency:
  - Completion of the head entry -> ret_valid high on the next cycle (the complete bit is registered; no completion-to-retire bypass).
  - Maximum throughput: one allocation, one completion and one retire per cycle.
- count update:
  - +1 on allocation only; -1 on retire only.
  - Unchanged when both fire or neither fires.
- Ordering: retire is strictly in allocation order. A complete younger entry waits behind an incomplete head.
- No flush or branch recovery in this block; rst is the only clear.

Test Plan:
- Reset: assert rst mid-cycle -> immediately alloc_ready=1, empty=1, count=0, ret_valid=0, alloc_idx=0.
- In-order retire: allocate rd=1/2/3, pd=32/33/34, old_pd=1/2/3 -> alloc_idx 0,1,2, count=3. Complete idx2 (0xAA) -> ret_valid stays 0. Complete idx0 (0x11) -> next cycle ret_valid=1, ret_rd=1, ret_pd=32, ret_old_pd=1, ret_result=0x11. Retire; idx1 blocks until completed (0x22). Then idx1 and idx2 (0xAA) retire back-to-back; empty=1.
- Full: 16 allocations without retire -> count=16, alloc_ready=0. Complete head, then on the retire cycle hold alloc_valid=1 -> retire fires (ret_rd of idx0), allocation rejected, count=15. The next cycle the allocation is accepted with alloc_idx=0.
- Wrap: 20 sequential alloc/complete/retire pairs -> alloc_idx sequence 0..15,0..3, retire order matches allocation order, count never exceeds 1.
- Stall/ignore: complete head with ret_ready=0 for 3 cycles -> ret_valid=1 and ret_* constant. cmp_valid to unallocated idx 9 -> no entry changes; idx 9 allocated later shows complete=0 (does not retire until completed).
- Simultaneous: with count=5, fire alloc and retire in the same cycle -> count stays 5, head and tail both advance. Assert rst -> count=0, ret_valid=0 asynchronously; no retire on the next edge.
